neuron_sample_feeder: RTL and testbench
=======================================

# neuron_sample_feeder

Upstream data source for the perceptron training neuron. It buffers a training set of (x1, x2, t) samples written by the host. It serves one sample per request over the requestFlag/dataReady handshake, cycling through the set in order and wrapping at the end of each epoch. It also drives the neuron's 32-bit sample-count input (nInput).

## Interface
Parameters:
- DEPTH, 64, sample buffer depth (power of two)
- AW, 6, address width, log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wrEn  in  1  write one sample at wrPtr
- wrX1, wrX2  in  7 each  sample inputs (two's complement)
- wrT  in  2  sample target
- clear  in  1  sync: empty buffer, zero both pointers
- rewind  in  1  sync: rdPtr := 0 (epoch restart)
- requestFlag  in  1  neuron requests next sample
- dataReady  out  1  one-cycle pulse: outputs hold a new sample
- x1Output, x2Output  out  7 each  current sample
- tOutput  out  2  current target
- nOutput  out  32  zero-extended sample count (to neuron nInput)
- epochEnd  out  1  pulses with dataReady when the delivered sample is index count-1
- empty, full  out  1 each  count==0 / count==DEPTH

## Operation
- Storage: DEPTH x 16-bit array {x1,x2,t}; wrPtr, rdPtr (AW bits), count (AW+1 bits).
- Write: wrEn && !full: mem[wrPtr] := sample; wrPtr++; count++. wrEn while full is ignored and leaves pointers and count unchanged.
- clear has priority over wrEn; it sets wrPtr=rdPtr=count=0 and forces the FSM to IDLE.
- FSM states and transitions:
  - IDLE: requestFlag && !empty -> FETCH. requestFlag while empty stays in IDLE, with no dataReady and no error.
  - FETCH: output regs := mem[rdPtr]; epochEndNext := (rdPtr==count-1); -> READY.
  - READY: dataReady=1, epochEnd=epochEndNext. rdPtr := (rdPtr==count-1) ? 0 : rdPtr+1. -> IDLE.
- rewind in any state sets rdPtr := 0 and wins over the READY increment. It does not abort an in-flight FETCH/READY, so the sample already latched is delivered.
- Writes are allowed in every state. FETCH uses the count value present in that cycle.
- Output data regs hold their value until the next FETCH.
- nOutput = {0, count}, updated the cycle after each write or clear.

## Timing
- Reset values:
  - dataReady=0, epochEnd=0
  - x1Output, x2Output, tOutput = 0
  - nOutput=0, empty=1, full=0
  - FSM in IDLE, pointers 0
- Memory contents are not reset.
- Latency: request sampled high at edge k in IDLE -> FETCH after k -> dataReady high for the cycle after edge k+1. Data is valid in the same cycle dataReady is high.
- Throughput: at most one sample per 3 cycles.
- The requester must drop requestFlag in the dataReady cycle or the cycle after. If requestFlag is still high when the FSM is back in IDLE, it is accepted as a new request.
- Wrap: after the last sample, the next delivery is index 0.
- Single-sample set (count=1): every delivery has epochEnd=1.
- Reset asserted mid-FETCH/READY: immediate return to the reset values; the partially fetched sample is lost.

## Structure
- Shared package neuron_pkg:
  - X_WIDTH=7, T_WIDTH=2, N_WIDTH=32
  - sample struct {x1,x2,t}
  - feeder state enum {IDLE,FETCH,READY}
- One sub-module, neuron_sample_mem: DEPTH x 16 register array, one synchronous write port, one combinational read port. Pointers, count and FSM stay in the top module.

## Test plan
- Reset: assert rst mid-cycle -> all outputs at reset values immediately; empty=1; nOutput=0.
- Load 3 samples (x1=5,x2=-3,t=1), (1,2,0), (-7,4,1); issue 4 requests -> nOutput=3. Samples delivered in order 0,1,2,0, each with dataReady 2 cycles after the accepted request. epochEnd=1 only on the third delivery.
- requestFlag held high with empty buffer for 10 cycles -> dataReady stays 0. Write 1 sample -> dataReady within 3 cycles with epochEnd=1.
- Write DEPTH+2 samples -> full=1, nOutput=64, wrPtr wraps to 0. The extra writes are dropped; reading index 0 returns the first sample.
- rewind pulsed in the same cycle as a READY after sample 1 of 3 -> next delivery is sample 0. clear during FETCH -> empty=1 and no further dataReady.
- rst asserted during FETCH -> no dataReady. After release, nOutput=0 and a request stays pending with no dataReady until a write occurs.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types for the perceptron neuron datapath.
//   X_WIDTH/T_WIDTH : sample feature / target widths
//   N_WIDTH         : width of the neuron's sample-count input
//   sample_t        : one training sample {x1, x2, t}
//   feeder_state_e  : sample feeder FSM states
package neuron_pkg;

  localparam int unsigned X_WIDTH = 7;
  localparam int unsigned T_WIDTH = 2;
  localparam int unsigned N_WIDTH = 32;

  typedef struct packed {
    logic [X_WIDTH-1:0] x1;
    logic [X_WIDTH-1:0] x2;
    logic [T_WIDTH-1:0] t;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/neuron_sample_feeder_if.sv
// Feeder-to-neuron sample handshake.
//   requestFlag          : neuron asks for the next sample
//   dataReady            : one-cycle pulse, sample outputs are new
//   x1Output/x2Output/tOutput : current sample
//   nOutput              : number of samples in the training set
//   epochEnd             : delivered sample is the last of the set
interface neuron_sample_feeder_if;
  import neuron_pkg::*;

  logic               requestFlag;
  logic               dataReady;
  logic [X_WIDTH-1:0] x1Output;
  logic [X_WIDTH-1:0] x2Output;
  logic [T_WIDTH-1:0] tOutput;
  logic [N_WIDTH-1:0] nOutput;
  logic               epochEnd;

  modport master (
    input  requestFlag,
    output dataReady, x1Output, x2Output, tOutput, nOutput, epochEnd
  );

  modport slave (
    output requestFlag,
    input  dataReady, x1Output, x2Output, tOutput, nOutput, epochEnd
  );

endinterface

// File: rtl/neuron_sample_mem.sv
// Sample buffer: DEPTH x sample_t register array, synchronous write,
// combinational read. Contents are intentionally not reset.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : asynchronous read port
module neuron_sample_mem
  import neuron_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  sample_t       wdata,
  input  logic [AW-1:0] raddr,
  output sample_t       rdata
);

  sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/neuron_sample_feeder.sv
// Buffers a host-written training set and serves it to the neuron one
// sample per request, cycling through the set in order.
//   clk, rst        : clock, asynchronous active-high reset
//   wrEn/wrX1/wrX2/wrT : host sample write (dropped while full)
//   clear           : empty the buffer, zero pointers, return to IDLE
//   rewind          : restart the epoch at sample 0
//   empty, full     : buffer occupancy flags
//   nrn             : neuron-side handshake and sample outputs
module neuron_sample_feeder
  import neuron_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic [X_WIDTH-1:0] wrX1,
  input  logic [X_WIDTH-1:0] wrX2,
  input  logic [T_WIDTH-1:0] wrT,
  input  logic               clear,
  input  logic               rewind,
  output logic               empty,
  output logic               full,
  neuron_sample_feeder_if.master nrn
);

  feeder_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  sample_t       out_q, out_d;
  logic          data_ready_q, data_ready_d;
  logic          epoch_end_q, epoch_end_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;

  sample_t       mem_rdata;
  sample_t       wr_sample_c;
  logic          wr_accept_c;
  logic          last_c;

  assign wr_sample_c = '{x1: wrX1, x2: wrX2, t: wrT};
  assign wr_accept_c = wrEn && (count_q != (AW+1)'(DEPTH)) && !clear;
  // Read pointer sits on the final sample of the current set
  assign last_c      = ((AW+1)'(rd_ptr_q) == (count_q - (AW+1)'(1)));

  neuron_sample_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_accept_c),
    .waddr (wr_ptr_q),
    .wdata (wr_sample_c),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Next-state, pointer and output computation
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_d        = out_q;
    data_ready_d = 1'b0;
    epoch_end_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (nrn.requestFlag && (count_q != '0)) state_d = FETCH;
      end
      FETCH: begin
        out_d        = mem_rdata;
        data_ready_d = 1'b1;
        epoch_end_d  = last_c;
        state_d      = READY;
      end
      READY: begin
        rd_ptr_d = last_c ? '0 : rd_ptr_q + AW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Rewind overrides the READY advance but lets the latched sample go out
    if (rewind) rd_ptr_d = '0;

    if (wr_accept_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + (AW+1)'(1);
    end

    // Clear aborts any fetch in progress, so no pulse follows it
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      state_d      = IDLE;
      out_d        = out_q;
      data_ready_d = 1'b0;
      epoch_end_d  = 1'b0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_q        <= '0;
      data_ready_q <= 1'b0;
      epoch_end_q  <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      data_ready_q <= data_ready_d;
      epoch_end_q  <= epoch_end_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
    end
  end

  assign empty        = empty_q;
  assign full         = full_q;
  assign nrn.dataReady = data_ready_q;
  assign nrn.epochEnd  = epoch_end_q;
  assign nrn.x1Output  = out_q.x1;
  assign nrn.x2Output  = out_q.x2;
  assign nrn.tOutput   = out_q.t;
  assign nrn.nOutput   = N_WIDTH'(count_q);

endmodule

// File: tb/tb_neuron_sample_feeder.sv
// Scoreboard bench for neuron_sample_feeder: requests push the expected
// sample, a negedge monitor pops and compares on every dataReady pulse.
module tb_neuron_sample_feeder;
  import neuron_pkg::*;

  typedef struct packed {
    sample_t s;
    logic    eoe;
  } exp_t;

  logic clk;
  logic rst;
  logic wrEn;
  logic [X_WIDTH-1:0] wrX1, wrX2;
  logic [T_WIDTH-1:0] wrT;
  logic clear, rewind;
  logic empty, full;

  int total;
  int bad;
  exp_t exp_q[$];

  neuron_sample_feeder_if nif ();

  neuron_sample_feeder #(.DEPTH(64), .AW(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrX1   (wrX1),
    .wrX2   (wrX2),
    .wrT    (wrT),
    .clear  (clear),
    .rewind (rewind),
    .empty  (empty),
    .full   (full),
    .nrn    (nif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sample_t mk(input int a, input int b, input int t);
    sample_t s;
    s.x1 = 7'(a);
    s.x2 = 7'(b);
    s.t  = 2'(t);
    return s;
  endfunction

  function automatic sample_t sd(input int i);
    return mk(i, 100 - i, i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dataReady"}, 32'(nif.dataReady), 32'd0);
    chk({tag, "_epochEnd"},  32'(nif.epochEnd),  32'd0);
    chk({tag, "_x1"},        32'(nif.x1Output),  32'd0);
    chk({tag, "_x2"},        32'(nif.x2Output),  32'd0);
    chk({tag, "_t"},         32'(nif.tOutput),   32'd0);
    chk({tag, "_nOutput"},   nif.nOutput,        32'd0);
    chk({tag, "_empty"},     32'(empty),         32'd1);
    chk({tag, "_full"},      32'(full),          32'd0);
  endtask

  // Called at a negedge; returns one negedge later
  task automatic wr(input sample_t s);
    wrX1 = s.x1;
    wrX2 = s.x2;
    wrT  = s.t;
    wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  // Issue one request from IDLE; optionally pulse rewind in the READY cycle
  task automatic req(input sample_t s, input logic eoe, input int exp_lat, input bit do_rewind);
    int lat;
    bit got;
    exp_q.push_back('{s: s, eoe: eoe});
    nif.requestFlag = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (nif.dataReady) got = 1'b1;
    end
    chk("req_seen", 32'(got), 32'd1);
    if (got && exp_lat != 0) chk("req_latency", 32'(lat), 32'(exp_lat));
    nif.requestFlag = 1'b0;
    if (do_rewind) rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
  endtask

  // Request already pending on an empty buffer; a single write must satisfy it
  task automatic pending_write(input sample_t s);
    int n;
    bit got;
    exp_q.push_back('{s: s, eoe: 1'b1});
    wr(s);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      n++;
      if (nif.dataReady) got = 1'b1;
    end
    chk("pend_seen", 32'(got), 32'd1);
    chk("pend_latency", 32'(n), 32'd2);
    nif.requestFlag = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every dataReady pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && nif.dataReady) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got x1=%0h x2=%0h t=%0h with no request pending (t=%0t)",
                 nif.x1Output, nif.x2Output, nif.tOutput, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_x1",  32'(nif.x1Output), 32'(e.s.x1));
        chk("mon_x2",  32'(nif.x2Output), 32'(e.s.x2));
        chk("mon_t",   32'(nif.tOutput),  32'(e.s.t));
        chk("mon_eoe", 32'(nif.epochEnd), 32'(e.eoe));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    wrEn = 1'b0;
    wrX1 = '0;
    wrX2 = '0;
    wrT  = '0;
    clear = 1'b0;
    rewind = 1'b0;
    nif.requestFlag = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Three-sample set served in order with wrap
    wr(mk(5, -3, 1));
    wr(mk(1, 2, 0));
    wr(mk(-7, 4, 1));
    chk("n_three", nif.nOutput, 32'd3);
    chk("empty_three", 32'(empty), 32'd0);
    req(mk(5, -3, 1), 1'b0, 2, 1'b0);
    req(mk(1, 2, 0),  1'b0, 2, 1'b0);
    req(mk(-7, 4, 1), 1'b1, 2, 1'b0);
    req(mk(5, -3, 1), 1'b0, 2, 1'b0);

    // Rewind during READY of sample 1 -> next delivery is sample 0
    req(mk(1, 2, 0),  1'b0, 2, 1'b1);
    req(mk(5, -3, 1), 1'b0, 2, 1'b0);

    // Clear while in FETCH: no pulse follows
    nif.requestFlag = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    nif.requestFlag = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("noready_after_clear", 32'(nif.dataReady), 32'd0);
    end
    chk("empty_after_clear", 32'(empty), 32'd1);
    chk("n_after_clear", nif.nOutput, 32'd0);

    // Request on empty buffer is held off until a write arrives
    nif.requestFlag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("noready_empty", 32'(nif.dataReady), 32'd0);
    end
    pending_write(mk(3, -1, 2));
    req(mk(3, -1, 2), 1'b1, 2, 1'b0);

    // Overfill: extra writes dropped, index 0 still the first sample
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 66; i++) wr(sd(i));
    chk("full_after_fill", 32'(full), 32'd1);
    chk("empty_after_fill", 32'(empty), 32'd0);
    chk("n_after_fill", nif.nOutput, 32'd64);
    req(sd(0), 1'b0, 2, 1'b0);
    req(sd(1), 1'b0, 2, 1'b0);
    chk("full_after_reads", 32'(full), 32'd1);

    // Reset asserted mid-FETCH takes effect immediately
    nif.requestFlag = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_fetch");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("noready_post_rst", 32'(nif.dataReady), 32'd0);
    end
    chk("n_post_rst", nif.nOutput, 32'd0);
    pending_write(mk(63, -64, 3));

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
